// File: rtl/icache_axi_refill_master.sv
// icache_axi_refill_master: AXI4 read master that fetches one I-cache line as a single INCR burst
// and returns it with a one-cycle done pulse. Rev 1.0
`default_nettype none

module icache_axi_refill_master #(
  parameter int ADDR_WIDTH     = 64,
  parameter int LINE_WIDTH     = 256,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int ID_WIDTH       = 4,
  parameter int AXI_ID         = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_mem_req,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  output logic                      o_mem_done,
  output logic [LINE_WIDTH-1:0]     o_line,
  output logic                      o_err,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  output logic [ID_WIDTH-1:0]       o_arid,
  input  logic                      i_rvalid,
  output logic                      o_rready,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast
);

  localparam int BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AR    = 2'd1,
    RDATA = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             err_sticky;
  logic             beat_ok;
  logic             beat_last;
  logic             beat_bad;
  logic             unused_addr_bits;

  assign o_arlen   = 8'(BEATS - 1);
  assign o_arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign o_arburst = 2'b01;
  assign o_arid    = ID_WIDTH'(AXI_ID);

  // Line offset bits are always forced to zero on the bus.
  assign unused_addr_bits = ^i_addr[4:0];

  assign beat_ok   = i_rvalid & o_rready;
  assign beat_last = (cnt == LAST_CNT);
  // A beat is bad on a non-OKAY response or when RLAST disagrees with our own beat count.
  assign beat_bad  = (i_rresp != 2'b00) | (i_rlast != beat_last);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      err_sticky <= 1'b0;
      o_arvalid  <= 1'b0;
      o_araddr   <= '0;
      o_rready   <= 1'b0;
      o_mem_done <= 1'b0;
      o_err      <= 1'b0;
      o_line     <= '0;
    end else begin
      o_mem_done <= 1'b0;
      o_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (i_mem_req) begin
            o_araddr   <= {i_addr[ADDR_WIDTH-1:5], 5'b0};
            err_sticky <= 1'b0;
            cnt        <= '0;
            o_arvalid  <= 1'b1;
            state      <= AR;
          end
        end
        AR: begin
          if (i_arready) begin
            o_arvalid <= 1'b0;
            o_rready  <= 1'b1;
            state     <= RDATA;
          end
        end
        RDATA: begin
          if (beat_ok) begin
            for (int i = 0; i < BEATS; i++) begin
              if (cnt == CNT_W'(i)) begin
                o_line[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
              end
            end
            cnt        <= cnt + 1'b1;
            err_sticky <= err_sticky | beat_bad;
            // Burst ends on our count, regardless of where RLAST appeared.
            if (beat_last) begin
              o_rready   <= 1'b0;
              o_mem_done <= 1'b1;
              o_err      <= err_sticky | beat_bad;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache_axi_refill_master.sv
// tb_icache_axi_refill_master: directed refills with a queue-based scoreboard checked on done.
`default_nettype none

module tb_icache_axi_refill_master;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_req = 1'b0;
  logic [63:0]  addr_in = '0;
  logic         mem_done;
  logic [255:0] line;
  logic         err;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [3:0]   arid;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [63:0]  rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [255:0] line;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  icache_axi_refill_master dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_mem_req  (mem_req),
    .i_addr     (addr_in),
    .o_mem_done (mem_done),
    .o_line     (line),
    .o_err      (err),
    .o_arvalid  (arvalid),
    .i_arready  (arready),
    .o_araddr   (araddr),
    .o_arlen    (arlen),
    .o_arsize   (arsize),
    .o_arburst  (arburst),
    .o_arid     (arid),
    .i_rvalid   (rvalid),
    .o_rready   (rready),
    .i_rdata    (rdata),
    .i_rresp    (rresp),
    .i_rlast    (rlast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding refill.
  always @(negedge clk) begin
    if (mem_done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("line", line, e.line);
        chk("err", 256'(err), 256'(e.err));
        chk("done_cycle", 256'(cyc), 256'(e.cyc));
      end
    end
  end

  task automatic refill(input logic [63:0] addr, input int stall, input logic [15:0] vpat,
                        input logic [7:0] resp, input logic [3:0] lastm, input logic [7:0] tag,
                        input logic exp_err, input int exp_delay, input bit junk_r,
                        input int abort_after);
    exp_t        e;
    logic [63:0] exp_addr;
    int          beat;
    int          idx;
    int          t;
    logic        v;
    exp_addr = {addr[63:5], 5'b0};
    for (int i = 0; i < 4; i++) e.line[i*64 +: 64] = {8{tag + 8'(i)}};
    e.err = exp_err;
    @(posedge clk); #1;
    e.cyc = cyc + exp_delay;
    if (abort_after < 0) sb.push_back(e);
    mem_req = 1'b1;
    addr_in = addr;
    arready = (stall == 0);
    @(posedge clk); #1;
    chk("arvalid_c1", 256'(arvalid), 256'(1));
    chk("araddr", 256'(araddr), 256'(exp_addr));
    chk("ar_consts", 256'({arlen, arsize, arburst, arid}), 256'({8'd3, 3'd3, 2'b01, 4'd0}));
    for (int s = 0; s < stall; s++) begin
      rvalid = junk_r;
      rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
      @(posedge clk); #1;
      chk("ar_hold", 256'({arvalid, araddr}), 256'({1'b1, exp_addr}));
      if (s == stall - 1) arready = 1'b1;
    end
    rvalid = 1'b0;
    @(posedge clk); #1;
    arready = 1'b0;
    beat = 0;
    idx  = 0;
    t    = 0;
    while (beat < 4 && t < 200) begin
      if (abort_after >= 0 && beat == abort_after) begin
        rvalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("abort_outputs", 256'({arvalid, rready, mem_done, err, araddr}), 256'(0));
        chk("abort_line", line, 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        mem_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        return;
      end
      v = 1'b0;
      if (rready) begin
        v = vpat[idx % 16];
        idx++;
      end
      rvalid = v;
      rdata  = {8{tag + 8'(beat)}};
      rresp  = resp[2*beat +: 2];
      rlast  = lastm[beat];
      @(posedge clk); #1;
      if (v && rready !== 1'bx) beat++;
      t++;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    t = 0;
    while (mem_done !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 50 cycles");
    end
    mem_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 256'({arvalid, rready, mem_done, err, araddr}), 256'(0));
    chk("reset_line", line, 256'(0));
    rst = 1'b0;
    // Back-to-back beats, minimum latency
    refill(64'h0000_0000_0000_1234, 0, 16'hFFFF, 8'h00, 4'b1000, 8'hA0, 1'b0, 6, 1'b0, -1);
    // AR stall for 5 cycles, stray RVALID during AR
    refill(64'h0000_0001_2345_67FF, 5, 16'hFFFF, 8'h00, 4'b1000, 8'h10, 1'b0, 11, 1'b1, -1);
    // beat, idle, idle, beat, beat, idle, beat
    refill(64'h0000_0000_0000_0040, 0, 16'h0059, 8'h00, 4'b1000, 8'h20, 1'b0, 9, 1'b0, -1);
    // SLVERR on beat 1
    refill(64'h0000_0000_0000_0060, 0, 16'hFFFF, 8'b0000_1000, 4'b1000, 8'h30, 1'b1, 6, 1'b0, -1);
    // clean refill after error
    refill(64'h0000_0000_0000_0080, 0, 16'hFFFF, 8'h00, 4'b1000, 8'h40, 1'b0, 6, 1'b0, -1);
    // early RLAST on beat 2
    refill(64'h0000_0000_0000_00A0, 0, 16'hFFFF, 8'h00, 4'b0100, 8'h50, 1'b1, 6, 1'b0, -1);
    // RLAST never asserted
    refill(64'h0000_0000_0000_00C0, 0, 16'hFFFF, 8'h00, 4'b0000, 8'h60, 1'b1, 6, 1'b0, -1);
    // reset after 2 beats, then a normal refill
    refill(64'h0000_0000_0000_00E0, 0, 16'hFFFF, 8'h00, 4'b1000, 8'h70, 1'b0, 6, 1'b0, 2);
    refill(64'hFFFF_FFFF_FFFF_FFFF, 0, 16'hFFFF, 8'h00, 4'b1000, 8'h80, 1'b0, 6, 1'b0, -1);
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 256'(sb.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icache_axi_refill_master.md
Name: icache_axi_refill_master

Overview:
AXI4 read master that services instruction-cache line refills for the core I-cache controller.
- Accepts a line-fill request (mem_req/addr) from the controller.
- Issues one INCR burst on a narrower AXI read channel and assembles the beats into a full cache line.
- Returns the line with a single-cycle done pulse, which the controller uses to enter its cache-update state.
- Sits directly downstream of the I-cache controller and upstream of the I-cache data array's block-replace port.

Parameters:
ADDR_WIDTH, 64, request and AXI address width
LINE_WIDTH, 256, cache line width in bits (32-byte line, 5 offset bits)
AXI_DATA_WIDTH, 64, AXI R-channel data width; LINE_WIDTH must be an integer multiple of it
ID_WIDTH, 4, AXI ID width
AXI_ID, 0, constant ARID value driven on every request

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  asynchronous, active-high reset
i_mem_req  input  1  refill request from I-cache controller, held high until o_mem_done
i_addr  input  ADDR_WIDTH  refill address (line-aligned by controller; low 5 bits forced to 0 here anyway)
o_mem_done  output  1  one-cycle pulse: o_line valid
o_line  output  LINE_WIDTH  assembled line, beat 0 in bits [AXI_DATA_WIDTH-1:0]
o_err  output  1  valid with o_mem_done: any non-OKAY RRESP or RLAST mismatch in this burst
o_arvalid  output  1  AXI AR valid
i_arready  input  1  AXI AR ready
o_araddr  output  ADDR_WIDTH  AXI AR address
o_arlen  output  8  constant BEATS-1 (3 by default)
o_arsize  output  3  constant log2(AXI_DATA_WIDTH/8) (3 by default)
o_arburst  output  2  constant 2'b01 (INCR)
o_arid  output  ID_WIDTH  constant AXI_ID
i_rvalid  input  1  AXI R valid
o_rready  output  1  AXI R ready
i_rdata  input  AXI_DATA_WIDTH  AXI R data
i_rresp  input  2  AXI R response
i_rlast  input  1  AXI R last

Behaviour:
- Reset is asynchronous and active-high.
  - All outputs reset to 0: o_arvalid, o_rready, o_mem_done, o_err, o_line, and o_araddr.
  - The FSM resets to IDLE and the beat counter to 0.
- BEATS = LINE_WIDTH/AXI_DATA_WIDTH; the beat counter is clog2(BEATS) bits wide.
- FSM states: IDLE, AR, RDATA, DONE. All outputs are registered except the constant AR fields.
- IDLE:
  - If i_mem_req=1, latch o_araddr = {i_addr[ADDR_WIDTH-1:5], 5'b0}.
  - Clear the sticky error and the beat counter, set o_arvalid=1, and go to AR.
  - Otherwise stay in IDLE.
- AR:
  - Hold o_arvalid and o_araddr stable until i_arready=1.
  - On the handshake cycle, o_arvalid goes to 0 and o_rready goes to 1 next cycle; the FSM moves to RDATA.
- RDATA:
  - Each cycle with i_rvalid & o_rready writes i_rdata into o_line[cnt*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] and increments cnt.
  - The error flag is set sticky if i_rresp != 2'b00.
  - The error flag is also set if i_rlast != (cnt==BEATS-1).
  - On the beat with cnt==BEATS-1, o_rready goes to 0 and the FSM moves to DONE.
  - The burst is always terminated by beat count, never by an early i_rlast.
- DONE:
  - o_mem_done=1 and o_err=sticky error for exactly one cycle.
  - o_line is stable from this cycle until the next refill writes beat 0.
  - Unconditionally return to IDLE.
- Minimum latency, with i_arready already high and i_rvalid continuous:
  - Request seen at cycle 0, o_arvalid at cycle 1.
  - Beats at cycles 2..5.
  - o_mem_done at cycle 6.
- i_mem_req is sampled only in IDLE; changes in other states are ignored.
  - The controller drops req combinationally with done, so IDLE after DONE sees req=0. A new refill needs req high again in IDLE.
- i_rvalid while not in RDATA is ignored (o_rready=0).
- Stalls (i_arready=0, i_rvalid gaps) extend the corresponding state indefinitely; there is no timeout.
- Reset mid-burst aborts to IDLE immediately and no done pulse is produced. The system resets the AXI slave in the same reset domain.
- The block has only one outstanding transaction; RID is not checked.

Test Plan:
- Request addr 0x0000_0000_0000_1234 with arready=1 and 4 back-to-back beats 0xA0..,0xA1..,0xA2..,0xA3.. (rlast on beat 3):
  - araddr=0x...1220, arlen=3, arsize=3, arburst=1.
  - o_line={A3,A2,A1,A0}, o_err=0.
  - o_mem_done pulses exactly at cycle 6.
- arready held 0 for 5 cycles:
  - o_arvalid stays 1 and o_araddr stays stable throughout.
  - Done pulse delayed by exactly 5 cycles.
- rvalid gaps (beat, idle, idle, beat, beat, idle, beat): line assembled in correct order; done on the cycle after the 4th beat.
- RRESP=2'b10 on beat 1 and OKAY on the others:
  - All 4 beats are still consumed.
  - o_err=1 with done.
  - The next clean refill reports o_err=0.
- rlast asserted on beat 2: o_err=1, 4 beats still accepted, done after beat 3. Separately, rlast never asserted: o_err=1.
- i_rst pulsed during RDATA after 2 beats:
  - Outputs go to 0 immediately and the FSM returns to IDLE with no o_mem_done.
  - A following request completes normally.
